// File: rtl/rvx_uart_sync_fifo_if.sv
// Handshake and status bundle between the UART register block (master) and the FIFO (slave).
// push/pop are single-cycle requests; push is taken when !full or pop, pop is taken when !empty.
interface rvx_uart_sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  flush;
    logic                  push;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  pop;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  full;
    logic                  empty;
    logic                  afull;
    logic                  aempty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  clr_err;

    modport master (
        output flush, push, wdata, pop, clr_err,
        input  rdata, full, empty, afull, aempty, count, overflow, underflow
    );

    modport slave (
        input  flush, push, wdata, pop, clr_err,
        output rdata, full, empty, afull, aempty, count, overflow, underflow
    );
endinterface

// File: rtl/rvx_uart_sync_fifo.sv
// Single-clock show-ahead FIFO for UART TX/RX buffering with occupancy flags,
// flush and sticky overflow/underflow reporting.
module rvx_uart_sync_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_LEVEL  = 12,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                clk,
    input  logic                rst,
    rvx_uart_sync_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH + 1)'(AEMPTY_LEVEL);
    localparam logic [ADDR_WIDTH:0] ONE_CNT    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_PTR  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic full_w;
    logic empty_w;
    logic push_ok;
    logic pop_ok;

    assign full_w  = (count_q == DEPTH_CNT);
    assign empty_w = (count_q == '0);

    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign push_ok = bus.push & (~full_w | bus.pop);
    assign pop_ok  = bus.pop & ~empty_w;

    assign bus.rdata     = mem[rptr];
    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
    assign bus.afull     = (count_q >= AFULL_CNT);
    assign bus.aempty    = (count_q <= AEMPTY_CNT);
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

    // Storage carries no reset; it is only meaningful between rptr and wptr.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && push_ok) begin
            mem[wptr] <= bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr <= wptr + ONE_PTR;
            if (pop_ok)  rptr <= rptr + ONE_PTR;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + ONE_CNT;
                2'b01:   count_q <= count_q - ONE_CNT;
                default: count_q <= count_q;
            endcase
        end
    end

    // Requests swallowed by a flush are not errors; a fresh error beats clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (!bus.flush && bus.push && full_w && !bus.pop) overflow_q <= 1'b1;
            else if (bus.clr_err)                             overflow_q <= 1'b0;

            if (!bus.flush && bus.pop && empty_w) underflow_q <= 1'b1;
            else if (bus.clr_err)                 underflow_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rvx_uart_sync_fifo.sv
// Directed bench for rvx_uart_sync_fifo: fill/drain, wrap, simultaneous push/pop,
// error flags, flush and reset mid-stream.
module tb_rvx_uart_sync_fifo;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    rvx_uart_sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    rvx_uart_sync_fifo #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.flush   = 1'b0;
        bus.clr_err = 1'b0;
        bus.wdata   = '0;
    endtask

    task automatic fill_ramp(input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            bus.push  = 1'b1;
            bus.wdata = base + 8'(i);
            tick();
        end
        idle();
    endtask

    task automatic test_reset();
        logic [5:0] st;
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        st = {bus.full, bus.empty, bus.afull, bus.aempty, bus.overflow, bus.underflow};
        n_tests++;
        if (st !== 6'b010100) begin
            n_fail++;
            $display("FAIL reset_flags got %b expected %b", st, 6'b010100);
        end
        n_tests++;
        if (bus.count !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_count got %0d expected 0", bus.count);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            bus.push  = 1'b1;
            bus.wdata = 8'(i + 1);
            tick();
            n_tests++;
            if (bus.count !== 5'(i + 1) || bus.afull !== (i + 1 >= 12) || bus.full !== (i == 15)) begin
                n_fail++;
                $display("FAIL fill_%0d got count=%0d afull=%b full=%b expected count=%0d afull=%b full=%b",
                         i, bus.count, bus.afull, bus.full, i + 1, (i + 1 >= 12), (i == 15));
            end
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (bus.rdata !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL drain_data_%0d got %h expected %h", i, bus.rdata, 8'(i + 1));
            end
            bus.pop = 1'b1;
            tick();
            n_tests++;
            if (bus.count !== 5'(15 - i) || bus.aempty !== (15 - i <= 2) || bus.empty !== (i == 15)) begin
                n_fail++;
                $display("FAIL drain_%0d got count=%0d aempty=%b empty=%b expected count=%0d aempty=%b empty=%b",
                         i, bus.count, bus.aempty, bus.empty, 15 - i, (15 - i <= 2), (i == 15));
            end
        end
        idle();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            bus.push  = 1'b1;
            bus.wdata = 8'(8'h30 + i);
            tick();
        end
        idle();
        bus.pop = 1'b1;
        repeat (10) tick();
        idle();
        fill_ramp(8'hA0);
        n_tests++;
        if (bus.full !== 1'b1 || bus.count !== 5'd16) begin
            n_fail++;
            $display("FAIL wrap_full got full=%b count=%0d expected full=1 count=16", bus.full, bus.count);
        end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (bus.rdata !== 8'(8'hA0 + i)) begin
                n_fail++;
                $display("FAIL wrap_data_%0d got %h expected %h", i, bus.rdata, 8'(8'hA0 + i));
            end
            bus.pop = 1'b1;
            tick();
        end
        idle();
        n_tests++;
        if (bus.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_empty got %b expected 1", bus.empty);
        end
    endtask

    task automatic test_simul_full();
        logic [7:0] exp;
        fill_ramp(8'h01);
        bus.push  = 1'b1;
        bus.pop   = 1'b1;
        bus.wdata = 8'h55;
        tick();
        idle();
        n_tests++;
        if (bus.count !== 5'd16 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_full got count=%0d overflow=%b expected count=16 overflow=0",
                     bus.count, bus.overflow);
        end
        for (int i = 0; i < 16; i++) begin
            exp = (i == 15) ? 8'h55 : 8'(i + 2);
            n_tests++;
            if (bus.rdata !== exp) begin
                n_fail++;
                $display("FAIL simul_full_data_%0d got %h expected %h", i, bus.rdata, exp);
            end
            bus.pop = 1'b1;
            tick();
        end
        idle();
    endtask

    task automatic test_simul_empty();
        bus.push  = 1'b1;
        bus.pop   = 1'b1;
        bus.wdata = 8'h77;
        tick();
        idle();
        n_tests++;
        if (bus.count !== 5'd1 || bus.underflow !== 1'b1 || bus.rdata !== 8'h77 || bus.empty !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_empty got count=%0d underflow=%b rdata=%h empty=%b expected 1 1 77 0",
                     bus.count, bus.underflow, bus.rdata, bus.empty);
        end
        bus.pop     = 1'b1;
        bus.clr_err = 1'b1;
        tick();
        idle();
        n_tests++;
        if (bus.empty !== 1'b1 || bus.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_empty_clear got empty=%b underflow=%b expected 1 0", bus.empty, bus.underflow);
        end
    endtask

    task automatic test_errors();
        fill_ramp(8'h01);
        bus.push  = 1'b1;
        bus.wdata = 8'hEE;
        tick();
        idle();
        n_tests++;
        if (bus.overflow !== 1'b1 || bus.count !== 5'd16 || bus.rdata !== 8'h01) begin
            n_fail++;
            $display("FAIL overflow_set got overflow=%b count=%0d rdata=%h expected 1 16 01",
                     bus.overflow, bus.count, bus.rdata);
        end
        bus.clr_err = 1'b1;
        tick();
        idle();
        n_tests++;
        if (bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear got %b expected 0", bus.overflow);
        end
        bus.clr_err = 1'b1;
        bus.push    = 1'b1;
        bus.wdata   = 8'hDD;
        tick();
        idle();
        n_tests++;
        if (bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_clr_race got %b expected 1", bus.overflow);
        end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (bus.rdata !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL overflow_data_%0d got %h expected %h", i, bus.rdata, 8'(i + 1));
            end
            bus.pop = 1'b1;
            tick();
        end
        idle();
        bus.pop = 1'b1;
        tick();
        idle();
        n_tests++;
        if (bus.underflow !== 1'b1 || bus.count !== 5'd0) begin
            n_fail++;
            $display("FAIL underflow_set got underflow=%b count=%0d expected 1 0", bus.underflow, bus.count);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            bus.push  = 1'b1;
            bus.wdata = 8'(8'hC0 + i);
            tick();
        end
        idle();
        bus.flush = 1'b1;
        bus.push  = 1'b1;
        bus.pop   = 1'b1;
        bus.wdata = 8'h99;
        tick();
        idle();
        n_tests++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.overflow !== 1'b1 || bus.underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL flush got count=%0d empty=%b ovf=%b unf=%b expected 0 1 1 1",
                     bus.count, bus.empty, bus.overflow, bus.underflow);
        end
        bus.push  = 1'b1;
        bus.wdata = 8'h3C;
        tick();
        idle();
        n_tests++;
        if (bus.rdata !== 8'h3C || bus.count !== 5'd1) begin
            n_fail++;
            $display("FAIL flush_next got rdata=%h count=%0d expected 3c 1", bus.rdata, bus.count);
        end
        bus.push  = 1'b1;
        bus.wdata = 8'h3D;
        tick();
        idle();
        bus.pop = 1'b1;
        tick();
        idle();
        n_tests++;
        if (bus.rdata !== 8'h3D || bus.count !== 5'd1) begin
            n_fail++;
            $display("FAIL flush_second got rdata=%h count=%0d expected 3d 1", bus.rdata, bus.count);
        end
    endtask

    task automatic test_reset_midstream();
        bus.push  = 1'b1;
        bus.wdata = 8'h11;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got count=%0d empty=%b ovf=%b unf=%b expected 0 1 0 0",
                     bus.count, bus.empty, bus.overflow, bus.underflow);
        end
        bus.push  = 1'b1;
        bus.wdata = 8'h5A;
        tick();
        idle();
        n_tests++;
        if (bus.rdata !== 8'h5A || bus.count !== 5'd1) begin
            n_fail++;
            $display("FAIL reset_mid_next got rdata=%h count=%0d expected 5a 1", bus.rdata, bus.count);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        idle();
        #2;
        tick();
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simul_full();
        test_simul_empty();
        test_errors();
        test_flush();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
